// File: rtl/mac_sequence_controller.sv
// Sequences one shared multiply-accumulate datapath over a stream of operand pairs.
// Optional macro MAC_SATURATE_EN: clamp Result to all ones on carry-out instead of wrapping.
module mac_sequence_controller #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 16,
    parameter int LEN_W  = 8
) (
    input  logic              clockPulse,
    input  logic              Reset,
    input  logic              start,
    input  logic [LEN_W-1:0]  vecLength,
    input  logic [DATA_W-1:0] numberOne,
    input  logic [DATA_W-1:0] numberTwo,
    input  logic              opValid,
    output logic              opReady,
    output logic [ACC_W-1:0]  Result,
    output logic              resultValid,
    output logic              busy,
    output logic              overflow
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t              r_state, w_next;
    logic [ACC_W-1:0]    r_result;
    logic [LEN_W-1:0]    r_count;
    logic                r_overflow;

    logic                w_hs;
    logic [2*DATA_W-1:0] w_prod;
    logic [ACC_W:0]      w_prod_ext;
    logic [ACC_W:0]      w_sum;

    assign w_hs       = opValid & (r_state == S_RUN);
    assign w_prod     = numberOne * numberTwo;
    assign w_prod_ext = {{(ACC_W+1-2*DATA_W){1'b0}}, w_prod};
    // Extra MSB of the sum is the carry-out used for overflow detection.
    assign w_sum      = {1'b0, r_result} + w_prod_ext;

    always_ff @(posedge clockPulse or negedge Reset) begin
        if (!Reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (start) w_next = (vecLength == '0) ? S_DONE : S_RUN;
            S_RUN:  if (w_hs && r_count == LEN_W'(1)) w_next = S_DONE;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clockPulse or negedge Reset) begin
        if (!Reset) begin
            r_result   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (r_state == S_IDLE && start) begin
                r_result   <= '0;
                r_overflow <= 1'b0;
                r_count    <= vecLength;
            end else if (w_hs) begin
                r_count <= r_count - LEN_W'(1);
                if (w_sum[ACC_W]) r_overflow <= 1'b1;
`ifdef MAC_SATURATE_EN
                // Once clamped, later pairs of the same operation leave it clamped.
                if (w_sum[ACC_W] || r_overflow) r_result <= '1;
                else                            r_result <= w_sum[ACC_W-1:0];
`else
                r_result <= w_sum[ACC_W-1:0];
`endif
            end
        end
    end

    assign opReady     = (r_state == S_RUN);
    assign resultValid = (r_state == S_DONE);
    assign busy        = (r_state == S_RUN) || (r_state == S_DONE);
    assign Result      = r_result;
    assign overflow    = r_overflow;

endmodule

// File: tb/tb_mac_sequence_controller.sv
// Directed bench for mac_sequence_controller: dot products, gaps, zero length, overflow, reset.
module tb_mac_sequence_controller;

    logic        clockPulse = 1'b0;
    logic        Reset      = 1'b0;
    logic        start      = 1'b0;
    logic [7:0]  vecLength  = '0;
    logic [7:0]  numberOne  = '0;
    logic [7:0]  numberTwo  = '0;
    logic        opValid    = 1'b0;
    logic        opReady;
    logic [15:0] Result;
    logic        resultValid;
    logic        busy;
    logic        overflow;

    int checks   = 0;
    int failures = 0;

    mac_sequence_controller #(.DATA_W(8), .ACC_W(16), .LEN_W(8)) dut (
        .clockPulse (clockPulse),
        .Reset      (Reset),
        .start      (start),
        .vecLength  (vecLength),
        .numberOne  (numberOne),
        .numberTwo  (numberTwo),
        .opValid    (opValid),
        .opReady    (opReady),
        .Result     (Result),
        .resultValid(resultValid),
        .busy       (busy),
        .overflow   (overflow)
    );

    always #5 clockPulse = ~clockPulse;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one rising edge; inputs change and outputs are sampled 1ns after it.
    task automatic step();
        @(posedge clockPulse);
        #1;
    endtask

    task automatic chk_outs(input string tag, input logic rdy, input logic [15:0] res,
                            input logic rv, input logic bsy, input logic ovf);
        chk({tag, ".opReady"},     32'(opReady),     32'(rdy));
        chk({tag, ".Result"},      32'(Result),      32'(res));
        chk({tag, ".resultValid"}, 32'(resultValid), 32'(rv));
        chk({tag, ".busy"},        32'(busy),        32'(bsy));
        chk({tag, ".overflow"},    32'(overflow),    32'(ovf));
    endtask

    task automatic pair(input logic [7:0] a, input logic [7:0] b);
        numberOne = a; numberTwo = b; opValid = 1'b1;
    endtask

    initial begin
        // Reset state
        #2;
        chk_outs("reset", 0, 0, 0, 0, 0);
        #10 Reset = 1'b1;
        step();
        chk_outs("idle", 0, 0, 0, 0, 0);

        // T1: back-to-back pairs, 6*7+2*3+5*9 = 93
        start = 1'b1; vecLength = 8'd3;
        step();
        start = 1'b0;
        chk_outs("t1.run", 1, 0, 0, 1, 0);
        pair(6, 7);  step(); chk("t1.p1", 32'(Result), 42);
        pair(2, 3);  step(); chk("t1.p2", 32'(Result), 48);
        pair(5, 9);  step(); opValid = 1'b0;
        chk_outs("t1.done", 0, 93, 1, 1, 0);
        step();
        chk_outs("t1.idle", 0, 93, 0, 0, 0);

        // T2: two idle cycles between pairs
        start = 1'b1; vecLength = 8'd3;
        step();
        start = 1'b0;
        chk("t2.clr", 32'(Result), 0);
        pair(6, 7); step(); opValid = 1'b0;
        step(); chk("t2.gap1.rdy", 32'(opReady), 1); chk("t2.gap1.res", 32'(Result), 42);
        step(); chk("t2.gap2.rdy", 32'(opReady), 1); chk("t2.gap2.rv", 32'(resultValid), 0);
        pair(2, 3); step(); opValid = 1'b0;
        step(); step(); chk("t2.gap3.res", 32'(Result), 48);
        pair(5, 9); step(); opValid = 1'b0;
        chk_outs("t2.done", 0, 93, 1, 1, 0);
        step();

        // T3: zero length goes straight to DONE
        start = 1'b1; vecLength = 8'd0; pair(4, 4);
        step();
        start = 1'b0;
        chk_outs("t3.done", 0, 0, 1, 1, 0);
        step();
        chk_outs("t3.idle", 0, 0, 0, 0, 0);
        opValid = 1'b0;

        // T4: 255*255*2 = 130050 -> carry-out
        start = 1'b1; vecLength = 8'd2;
        step();
        start = 1'b0;
        pair(255, 255); step(); chk("t4.p1", 32'(Result), 65025); chk("t4.p1.ovf", 32'(overflow), 0);
        pair(255, 255); step(); opValid = 1'b0;
`ifdef MAC_SATURATE_EN
        chk_outs("t4.done", 0, 16'd65535, 1, 1, 1);
`else
        chk_outs("t4.done", 0, 16'd64514, 1, 1, 1);
`endif
        step();
        chk("t4.idle.ovf", 32'(overflow), 1);

        // T5: second start during RUN is ignored; 3*4+1*1 = 13
        start = 1'b1; vecLength = 8'd2;
        step();
        chk("t5.ovfclr", 32'(overflow), 0);
        pair(3, 4);
        step();
        start = 1'b1; vecLength = 8'd5; pair(1, 1);
        step();
        start = 1'b0; opValid = 1'b0;
        chk_outs("t5.done", 0, 13, 1, 1, 0);
        step();
        chk_outs("t5.idle", 0, 13, 0, 0, 0);

        // T6: reset mid-RUN clears everything immediately
        start = 1'b1; vecLength = 8'd3;
        step();
        start = 1'b0;
        pair(6, 7); step(); opValid = 1'b0;
        chk("t6.partial", 32'(Result), 42);
        #2 Reset = 1'b0;
        #1;
        chk_outs("t6.rst", 0, 0, 0, 0, 0);
        step();
        Reset = 1'b1;
        step();
        chk_outs("t6.idle", 0, 0, 0, 0, 0);
        start = 1'b1; vecLength = 8'd1;
        step();
        start = 1'b0;
        chk("t6.run", 32'(opReady), 1);
        pair(10, 10); step(); opValid = 1'b0;
        chk_outs("t6.done", 0, 100, 1, 1, 0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
